// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Definitions shared by the operand-select pipeline (proc_mux_pipe) and its
// 2-entry skid buffer (proc_skid_buf):
//   DATA_WIDTH_DEF  : default channel width
//   buf_state_e     : occupancy state of the skid buffer
//   calc_sel_width  : width of an encoded select for n channels
// ---------------------------------------------------------------------------
package proc_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // EMPTY: nothing held, ONE: main stage only, FULL: main and skid stages
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // Select width for n channels; a single bit is the minimum even for n <= 2
    function automatic int calc_sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/proc_skid_buf.sv
// ---------------------------------------------------------------------------
// proc_skid_buf
// Generic 2-entry skid buffer with valid/ready handshakes on both sides and
// a synchronous flush. The main stage drives the outputs; the skid stage
// catches one extra entry when the consumer stalls. o_ready is registered,
// so it never depends combinationally on i_ready.
// Ports:
//   i_clk, i_rst_n       : clock, asynchronous active-low reset
//   i_flush              : synchronous discard of all entries
//   i_data/i_valid/o_ready : upstream handshake
//   o_data/o_valid/i_ready : downstream handshake
// ---------------------------------------------------------------------------
module proc_skid_buf
    import proc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    buf_state_e       r_state;
    buf_state_e       w_state_next;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in;
    logic             w_out;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    assign w_in  = i_valid && r_ready;
    assign w_out = r_valid && i_ready;

    // Next-state and datapath load enables
    always_comb begin
        w_state_next     = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            // flush beats any simultaneous transfer; data registers keep contents
            w_state_next = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_in) begin
                        w_state_next = BUF_ONE;
                        w_load_main  = 1'b1;
                    end else begin
                        w_state_next = BUF_EMPTY;
                    end
                end
                BUF_ONE: begin
                    if (w_in && w_out) begin
                        w_state_next = BUF_ONE;
                        w_load_main  = 1'b1;
                    end else if (w_in) begin
                        w_state_next = BUF_FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_out) begin
                        w_state_next = BUF_EMPTY;
                    end else begin
                        w_state_next = BUF_ONE;
                    end
                end
                BUF_FULL: begin
                    // r_ready is low here, so only the output side can move
                    if (w_out) begin
                        w_state_next     = BUF_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end else begin
                        w_state_next = BUF_FULL;
                    end
                end
                default: begin
                    w_state_next = BUF_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered handshake flags decoded from next state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= BUF_EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != BUF_FULL);
            r_valid <= (w_state_next != BUF_EMPTY);
        end
    end

    // Main and skid data registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main <= {WIDTH{1'b0}};
            r_skid <= {WIDTH{1'b0}};
        end else begin
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : i_data;
            end else begin
                r_main <= r_main;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end else begin
                r_skid <= r_skid;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_main;

endmodule

// File: rtl/proc_mux_pipe.sv
// ---------------------------------------------------------------------------
// proc_mux_pipe
// NUM_INPUTS:1 operand select mux with a fully registered valid/ready output
// (2-entry skid buffer). An out-of-range select yields all-zero data.
// Optional build macro: PROC_MUX_PIPE_SEL_ERR_EN adds the sticky o_sel_err
// flag, set after an accepted out-of-range select, cleared by reset/flush.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_mux_data            : NUM_INPUTS channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_mux_sel             : encoded select, sampled with i_valid
//   i_valid / o_ready     : upstream handshake (o_ready registered)
//   o_mux_data / o_valid  : registered result
//   i_ready               : downstream accept
//   i_flush               : synchronous discard of buffered entries
//   o_sel_q               : select that produced o_mux_data
//   o_sel_err             : (macro only) sticky out-of-range select flag
// ---------------------------------------------------------------------------
module proc_mux_pipe
    import proc_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int NUM_INPUTS = 4,
    localparam int SEL_WIDTH  = calc_sel_width(NUM_INPUTS)
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_mux_data,
    input  logic [SEL_WIDTH-1:0]             i_mux_sel,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [DATA_WIDTH-1:0]            o_mux_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    input  logic                             i_flush,
`ifdef PROC_MUX_PIPE_SEL_ERR_EN
    output logic                             o_sel_err,
`endif
    output logic [SEL_WIDTH-1:0]             o_sel_q
);

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_ready;

    // Channel select; no channel matches an out-of-range select, leaving zero
    always_comb begin
        w_sel_data = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_sel_data = (int'(i_mux_sel) == k) ?
                         i_mux_data[k*DATA_WIDTH +: DATA_WIDTH] : w_sel_data;
        end
    end

    proc_skid_buf #(
        .WIDTH (DATA_WIDTH + SEL_WIDTH)
    ) u_skid_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_data  ({i_mux_sel, w_sel_data}),
        .i_valid (i_valid),
        .o_ready (w_ready),
        .o_data  ({o_sel_q, o_mux_data}),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    assign o_ready = w_ready;

`ifdef PROC_MUX_PIPE_SEL_ERR_EN
    logic w_sel_oob;
    logic r_sel_err;

    assign w_sel_oob = (int'(i_mux_sel) >= NUM_INPUTS);

    // Sticky error flag; flush clears it and wins over a simultaneous bad select
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel_err <= 1'b0;
        end else if (i_flush) begin
            r_sel_err <= 1'b0;
        end else if (i_valid && w_ready && w_sel_oob) begin
            r_sel_err <= 1'b1;
        end else begin
            r_sel_err <= r_sel_err;
        end
    end

    assign o_sel_err = r_sel_err;
`endif

endmodule
